// File: rtl/mtx_burst_sched.sv
// mtx_burst_sched: host-armed, trigger-aligned burst sequencer for a multi-tone
// transmit generator. Each burst runs SYNC_HI, SYNC_LO, GUARD, TX and GAP; the
// generator reset, DAC gate and GPIO markers are decoded from the state register.
module mtx_burst_sched #(
    parameter int CNT_WIDTH    = 24,
    parameter int NBURST_WIDTH = 8,
    parameter int SYNC_LEN     = 8750,
    parameter int GUARD_LEN    = 1000,
    parameter int TX_LEN       = 40960,
    parameter int GAP_LEN      = 2000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trig_in,
    input  logic                    arm,
    input  logic [NBURST_WIDTH-1:0] nburst,
    input  logic                    abort,
    input  logic                    sig_ready,
    output logic                    sig_srst,
    output logic                    out_en,
    output logic                    sync_out,
    output logic                    tx_out,
    output logic                    busy,
    output logic                    done,
    output logic [NBURST_WIDTH-1:0] burst_cnt,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_SYNC_HI = 3'd2,
        ST_SYNC_LO = 3'd3,
        ST_GUARD   = 3'd4,
        ST_TX      = 3'd5,
        ST_GAP     = 3'd6
    } state_t;

    state_t                  r_state;
    state_t                  w_stateNext;
    logic [CNT_WIDTH-1:0]    r_cnt;
    logic [CNT_WIDTH-1:0]    w_stateLen;
    logic                    w_expire;
    logic                    w_timed;
    logic [NBURST_WIDTH-1:0] r_nburst;
    logic [NBURST_WIDTH-1:0] r_burstCnt;
    logic [NBURST_WIDTH:0]   w_burstPlusOne;
    logic                    w_lastBurst;
    logic                    w_armAccept;
    logic                    w_gapDone;
    logic                    w_finish;
    logic                    r_done;
    logic                    r_trigMeta;
    logic                    r_trigSync;
    logic                    r_trigPrev;
    logic                    w_trigEdge;

    // Two-flop synchronizer for the asynchronous trigger plus a history flop for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_trigMeta <= 1'b0;
            r_trigSync <= 1'b0;
            r_trigPrev <= 1'b0;
        end else begin
            r_trigMeta <= trig_in;
            r_trigSync <= r_trigMeta;
            r_trigPrev <= r_trigSync;
        end
    end

    assign w_trigEdge = r_trigSync & ~r_trigPrev;

    // Duration of the current timed state; untimed states never consult it
    always_comb begin
        w_stateLen = '0;
        w_timed    = 1'b1;
        case (r_state)
            ST_SYNC_HI: w_stateLen = CNT_WIDTH'(SYNC_LEN);
            ST_SYNC_LO: w_stateLen = CNT_WIDTH'(SYNC_LEN);
            ST_GUARD:   w_stateLen = CNT_WIDTH'(GUARD_LEN);
            ST_TX:      w_stateLen = CNT_WIDTH'(TX_LEN);
            ST_GAP:     w_stateLen = CNT_WIDTH'(GAP_LEN);
            default:    w_timed    = 1'b0;
        endcase
    end

    assign w_expire       = w_timed && (r_cnt == w_stateLen);
    // Compare one bit wider so a saturated count never wraps into a false match
    assign w_burstPlusOne = {1'b0, r_burstCnt} + {{NBURST_WIDTH{1'b0}}, 1'b1};
    assign w_lastBurst    = (r_nburst != '0) && (w_burstPlusOne == {1'b0, r_nburst});

    // Next-state logic: abort beats counter expiry, which beats arm
    always_comb begin
        w_stateNext = r_state;
        w_armAccept = 1'b0;
        w_gapDone   = 1'b0;
        w_finish    = 1'b0;
        if (abort && (r_state != ST_IDLE)) begin
            w_stateNext = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (arm) begin
                        w_stateNext = ST_ARMED;
                        w_armAccept = 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (w_trigEdge && sig_ready) begin
                        w_stateNext = ST_SYNC_HI;
                    end
                end
                ST_SYNC_HI: if (w_expire) w_stateNext = ST_SYNC_LO;
                ST_SYNC_LO: if (w_expire) w_stateNext = ST_GUARD;
                ST_GUARD:   if (w_expire) w_stateNext = ST_TX;
                ST_TX:      if (w_expire) w_stateNext = ST_GAP;
                ST_GAP: begin
                    if (w_expire) begin
                        w_gapDone = 1'b1;
                        if (w_lastBurst) begin
                            w_stateNext = ST_IDLE;
                            w_finish    = 1'b1;
                        end else begin
                            w_stateNext = ST_SYNC_HI;
                        end
                    end
                end
                default: w_stateNext = ST_IDLE;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Duration counter: restarts at 1 on every state change so a state lasts exactly LEN cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_stateNext != r_state) begin
            r_cnt <= CNT_WIDTH'(1);
        end else if (w_timed) begin
            r_cnt <= r_cnt + CNT_WIDTH'(1);
        end
    end

    // Burst request capture and saturating completed-burst counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_nburst   <= '0;
            r_burstCnt <= '0;
        end else if (w_armAccept) begin
            r_nburst   <= nburst;
            r_burstCnt <= '0;
        end else if (w_gapDone && (r_burstCnt != '1)) begin
            r_burstCnt <= r_burstCnt + NBURST_WIDTH'(1);
        end
    end

    // Completion pulse, registered so it lines up with the first IDLE cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= w_finish;
        end
    end

    assign sync_out  = (r_state == ST_SYNC_HI);
    assign out_en    = (r_state == ST_TX);
    assign tx_out    = (r_state == ST_TX);
    assign sig_srst  = (r_state != ST_TX);
    assign busy      = (r_state != ST_IDLE);
    assign done      = r_done;
    assign burst_cnt = r_burstCnt;
    assign state     = r_state;

endmodule

// File: tb/tb_mtx_burst_sched.sv
// tb_mtx_burst_sched: directed and randomized stimulus checked every cycle against
// a burst-position model (mode plus cycle offset within a burst).
module tb_mtx_burst_sched;

    localparam int SYNC  = 4;
    localparam int GUARD = 2;
    localparam int TXL   = 8;
    localparam int GAPL  = 3;
    localparam int BURST = 2 * SYNC + GUARD + TXL + GAPL;

    logic       clk = 1'b0;
    logic       reset;
    logic       trig_in;
    logic       arm;
    logic [7:0] nburst;
    logic       abort;
    logic       sig_ready;
    logic       sig_srst;
    logic       out_en;
    logic       sync_out;
    logic       tx_out;
    logic       busy;
    logic       done;
    logic [7:0] burst_cnt;
    logic [2:0] state;

    mtx_burst_sched #(
        .CNT_WIDTH(24), .NBURST_WIDTH(8), .SYNC_LEN(SYNC),
        .GUARD_LEN(GUARD), .TX_LEN(TXL), .GAP_LEN(GAPL)
    ) dut (
        .clk(clk), .reset(reset), .trig_in(trig_in), .arm(arm), .nburst(nburst),
        .abort(abort), .sig_ready(sig_ready), .sig_srst(sig_srst), .out_en(out_en),
        .sync_out(sync_out), .tx_out(tx_out), .busy(busy), .done(done),
        .burst_cnt(burst_cnt), .state(state)
    );

    // Free-running clock
    always #5 clk = ~clk;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef enum int {M_IDLE, M_ARMED, M_RUN} mode_t;
    mode_t mMode;
    int    mPos;
    int    mBurst;
    int    mNb;
    bit    mDone;
    bit    trigQ[$];

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void modelReset();
        mMode  = M_IDLE;
        mPos   = 0;
        mBurst = 0;
        mNb    = 0;
        mDone  = 0;
        trigQ  = '{1'b0, 1'b0, 1'b0};
    endfunction

    // One clock edge of the reference behaviour
    function automatic void modelStep(input bit a, input int nb, input bit ab, input bit rdy, input bit tr);
        bit trigEdge;
        trigQ.push_back(tr);
        trigEdge = trigQ[$-2] && !trigQ[$-3];
        while (trigQ.size() > 4) void'(trigQ.pop_front());
        mDone = 0;
        case (mMode)
            M_IDLE: begin
                if (a) begin
                    mMode  = M_ARMED;
                    mNb    = nb;
                    mBurst = 0;
                end
            end
            M_ARMED: begin
                if (ab) mMode = M_IDLE;
                else if (trigEdge && rdy) begin
                    mMode = M_RUN;
                    mPos  = 0;
                end
            end
            default: begin
                if (ab) mMode = M_IDLE;
                else if (mPos == BURST - 1) begin
                    if (mNb != 0 && mBurst + 1 == mNb) begin
                        mMode = M_IDLE;
                        mDone = 1;
                    end
                    mPos   = 0;
                    mBurst = (mBurst == 255) ? 255 : mBurst + 1;
                end else begin
                    mPos++;
                end
            end
        endcase
    endfunction

    function automatic int expState();
        if (mMode == M_IDLE)  return 0;
        if (mMode == M_ARMED) return 1;
        if (mPos < SYNC)                     return 2;
        if (mPos < 2 * SYNC)                 return 3;
        if (mPos < 2 * SYNC + GUARD)         return 4;
        if (mPos < 2 * SYNC + GUARD + TXL)   return 5;
        return 6;
    endfunction

    task automatic checkAll();
        int es;
        es = expState();
        checkOutput("state",     32'(state),     32'(es));
        checkOutput("sync_out",  32'(sync_out),  32'(es == 2));
        checkOutput("out_en",    32'(out_en),    32'(es == 5));
        checkOutput("tx_out",    32'(tx_out),    32'(es == 5));
        checkOutput("sig_srst",  32'(sig_srst),  32'(es != 5));
        checkOutput("busy",      32'(busy),      32'(es != 0));
        checkOutput("done",      32'(done),      32'(mDone));
        checkOutput("burst_cnt", 32'(burst_cnt), 32'(mBurst));
    endtask

    // Drive one cycle of inputs, advance one edge, then compare at the falling edge
    task automatic applyStimulus(input bit a, input int nb, input bit ab, input bit rdy, input bit tr);
        arm       = a;
        nburst    = 8'(nb);
        abort     = ab;
        sig_ready = rdy;
        trig_in   = tr;
        @(posedge clk);
        modelStep(a, nb, ab, rdy, tr);
        @(negedge clk);
        checkAll();
        arm   = 1'b0;
        abort = 1'b0;
    endtask

    task automatic idleCycles(input int n, input bit rdy, input bit tr);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, rdy, tr);
    endtask

    // Run until the model reaches a given offset in a burst, bounded by a cycle budget
    task automatic runUntilPos(input int target, input bit tr, input int budget);
        int n;
        n = 0;
        while (!(mMode == M_RUN && mPos == target) && n < budget) begin
            applyStimulus(0, 0, 0, 1, tr);
            n++;
        end
        checkOutput("reach_pos", 32'(mMode == M_RUN && mPos == target), 32'd1);
    endtask

    initial begin
        bit trigLevel;
        reset = 1'b1; arm = 0; abort = 0; nburst = 0; sig_ready = 0; trig_in = 0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        modelReset();
        checkAll();

        // Single burst
        applyStimulus(1, 1, 0, 1, 0);
        idleCycles(2, 1, 0);
        idleCycles(BURST + 6, 1, 1);
        checkOutput("single_cnt", 32'(burst_cnt), 32'd1);

        // Three bursts back to back
        idleCycles(2, 1, 0);
        applyStimulus(1, 3, 0, 1, 0);
        idleCycles(3 * BURST + 6, 1, 1);
        checkOutput("multi_cnt", 32'(burst_cnt), 32'd3);

        // Trigger gating: level at arm, not-ready edge, then a valid edge
        applyStimulus(1, 1, 0, 1, 1);
        idleCycles(8, 1, 1);
        checkOutput("gate_level", 32'(state), 32'd1);
        idleCycles(3, 1, 0);
        idleCycles(6, 0, 1);
        checkOutput("gate_notready", 32'(state), 32'd1);
        idleCycles(3, 1, 0);
        runUntilPos(0, 1, 10);
        idleCycles(BURST + 4, 1, 1);

        // Abort on the fifth TX cycle of a continuous run
        idleCycles(2, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        runUntilPos(2 * SYNC + GUARD + 4, 1, 40);
        applyStimulus(0, 0, 1, 1, 1);
        checkOutput("abort_idle", 32'(state), 32'd0);
        idleCycles(4, 1, 1);

        // Arm during GUARD of a two-burst run is ignored
        idleCycles(2, 1, 0);
        applyStimulus(1, 2, 0, 1, 0);
        runUntilPos(2 * SYNC, 1, 40);
        applyStimulus(1, 5, 0, 1, 1);
        idleCycles(2 * BURST + 6, 1, 1);
        checkOutput("armbusy_cnt", 32'(burst_cnt), 32'd2);

        // Asynchronous reset in the middle of TX
        idleCycles(2, 1, 0);
        applyStimulus(1, 1, 0, 1, 0);
        runUntilPos(2 * SYNC + GUARD + 2, 1, 40);
        #1 reset = 1'b1;
        #1;
        checkOutput("async_out_en", 32'(out_en),   32'd0);
        checkOutput("async_srst",   32'(sig_srst), 32'd1);
        checkOutput("async_state",  32'(state),    32'd0);
        checkOutput("async_busy",   32'(busy),     32'd0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; trig_in = 1'b0;
        modelReset();
        checkAll();

        // Long continuous run to reach counter saturation
        idleCycles(2, 1, 0);
        applyStimulus(1, 0, 0, 1, 0);
        idleCycles(2, 1, 0);
        idleCycles(257 * BURST, 1, 1);
        checkOutput("sat_cnt", 32'(burst_cnt), 32'd255);
        applyStimulus(0, 0, 1, 1, 1);

        // Randomized traffic
        trigLevel = 0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) trigLevel = ~trigLevel;
            applyStimulus($urandom_range(0, 19) == 0, int'($urandom_range(0, 3)),
                          $urandom_range(0, 149) == 0, $urandom_range(0, 3) != 0, trigLevel);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mtx_burst_sched.md
Name: mtx_burst_sched

Overview:
Burst scheduler that sequences a multi-tone transmit signal generator and its front-panel GPIO markers. The sequence is: arm, wait for an external trigger, then run N bursts. Each burst is sync-high, sync-low, guard, transmit window, then gap. The block drives the generator's synchronous reset, the DAC output gate and the sync/TX marker bits. It sits between GPIO control and the signal generator, replacing free-running sequencing with host-armed, trigger-aligned bursts.

Parameters:
CNT_WIDTH, 24, width of the per-state duration counter
NBURST_WIDTH, 8, width of the burst count request and completed-burst counter
SYNC_LEN, 8750, cycles in each of SYNC_HI and SYNC_LO (must be >= 1)
GUARD_LEN, 1000, cycles in GUARD (must be >= 1)
TX_LEN, 40960, cycles in TX (must be >= 1)
GAP_LEN, 2000, cycles in GAP (must be >= 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
trig_in  in  1  external trigger from GPIO input, asynchronous; synchronized internally
arm  in  1  one-cycle arm request; nburst is captured when armed
nburst  in  NBURST_WIDTH  bursts to run; 0 = continuous until abort
abort  in  1  one-cycle abort request
sig_ready  in  1  generator ready; gates trigger acceptance
sig_srst  out  1  generator synchronous reset
out_en  out  1  DAC IQ gate / tx_valid
sync_out  out  1  GPIO sync marker
tx_out  out  1  GPIO TX marker
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse on normal completion
burst_cnt  out  NBURST_WIDTH  completed bursts since the last arm
state  out  3  current state encoding (debug)

Behaviour:
- Reset (asynchronous): state=IDLE, sig_srst=1, out_en=0, sync_out=0, tx_out=0, busy=0, done=0, burst_cnt=0, sync flops=0.
- States and encodings: IDLE=0, ARMED=1, SYNC_HI=2, SYNC_LO=3, GUARD=4, TX=5, GAP=6. Code 7 is unreachable and recovers to IDLE on the next cycle.
- Output decode is combinational from the state register:
  - sync_out = (SYNC_HI)
  - out_en = tx_out = (TX)
  - sig_srst = ~(TX)
  - busy = ~(IDLE)
- Trigger path: two-flop synchronizer, then a third flop for rising-edge detect. If trig_in is first sampled high at edge k, the ARMED->SYNC_HI transition takes effect at edge k+2. A trigger already high at arm time does not fire; a fresh rising edge is required.
- Duration counter: loads 1 on entry to SYNC_HI, SYNC_LO, GUARD, TX and GAP. It increments each cycle and the state exits on the cycle where cnt == LEN, so each timed state lasts exactly LEN cycles.
- Transitions:
  - IDLE -> ARMED on arm. nburst is latched and burst_cnt cleared on the same edge.
  - ARMED -> SYNC_HI on trigger edge AND sig_ready. An edge while sig_ready=0 is dropped.
  - SYNC_HI -> SYNC_LO -> GUARD -> TX -> GAP, each on counter expiry.
  - GAP expiry increments burst_cnt (saturating at all-ones).
  - GAP expiry, latched nburst != 0 and burst_cnt+1 == nburst: go to IDLE and pulse done for 1 cycle, aligned with the IDLE entry.
  - GAP expiry otherwise: go to SYNC_HI.
- Generator timing: sig_srst deasserts on the first TX cycle, so the generator starts from its start phase exactly at TX entry. The generator is held in reset during GAP and the next sync.
- Priority: abort > counter expiry > arm.
  - abort in any non-IDLE state: IDLE on the next edge, no done pulse, burst_cnt holds.
  - abort in IDLE has no effect.
  - arm outside IDLE is ignored, including any nburst change.
- Simultaneous arm and abort in IDLE: arm wins, since abort is a no-op in IDLE.
- Mid-operation reset forces the reset values immediately; outputs drop asynchronously.

Test Plan:
1. Reset/idle (SYNC_LEN=4, GUARD_LEN=2, TX_LEN=8, GAP_LEN=3): assert reset mid-TX -> out_en falls without waiting for clk. After release: state=0, sig_srst=1, all markers 0.
2. Single burst: arm with nburst=1, sig_ready=1, trig rise at edge k.
   - sync_out high edges k+2..k+5; low SYNC_LO 4 cycles; GUARD 2 cycles.
   - out_en high 8 cycles with sig_srst=0.
   - GAP 3 cycles, then done pulses once, burst_cnt=1, busy=0.
3. Multi-burst: nburst=3 -> three identical 21-cycle bursts back-to-back from the first SYNC_HI; done follows the third GAP; burst_cnt=3.
4. Trigger gating:
   - trig already high at arm -> no start.
   - rise with sig_ready=0 -> stays ARMED.
   - next rise with sig_ready=1 -> starts.
5. Abort: nburst=0, abort on the 5th TX cycle -> IDLE next edge, out_en=0, sig_srst=1, done stays 0, burst_cnt unchanged.
6. Arm while busy: arm with nburst=5 during GUARD of an nburst=2 run -> ignored; run ends after 2 bursts.
